// File: rtl/gcd_arbiter_pkg.sv
// Shared definitions for the two-unit GCD arbiter: unit identifiers and the
// round-robin unit selection rule.
package gcd_arbiter_pkg;

  localparam logic GCD_UNIT0 = 1'b0;
  localparam logic GCD_UNIT1 = 1'b1;

  // Preferred unit wins if it is ready, otherwise fall back to the other one.
  function automatic logic pick_unit(input logic rr, input logic rdy0, input logic rdy1);
    logic pref_rdy;
    pref_rdy = (rr == GCD_UNIT0) ? rdy0 : rdy1;
    return pref_rdy ? rr : ~rr;
  endfunction

endpackage

// File: rtl/gcd_arb_tagq.sv
// Order queue of 1-bit unit tags. Full/empty come from the occupancy count so
// head==tail is never ambiguous.
module gcd_arb_tagq #(
  parameter int LOGDEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic head_id,
  output logic full,
  output logic empty
);

  localparam int DEPTH = 2 ** LOGDEPTH;

  logic [DEPTH-1:0]    mem_q,   mem_d;
  logic [LOGDEPTH-1:0] head_q,  head_d;
  logic [LOGDEPTH-1:0] tail_q,  tail_d;
  logic [LOGDEPTH:0]   count_q, count_d;
  logic                push_ok, pop_ok;

  assign full    = (count_q == (LOGDEPTH+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign head_id = mem_q[head_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_ok) begin
      mem_d[tail_q] = push_id;
      tail_d        = tail_q + LOGDEPTH'(1);
    end
    if (pop_ok) begin
      head_d = head_q + LOGDEPTH'(1);
    end
    // Simultaneous push and pop leaves the count alone.
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (LOGDEPTH+1)'(1);
      2'b01:   count_d = count_q - (LOGDEPTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Steers one GCD request stream across two units and returns results in
// request order. All handshakes are val && rdy in the same cycle; zero latency.
module gcd_arbiter
  import gcd_arbiter_pkg::*;
#(
  parameter int W        = 32,
  parameter int LOGDEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         operands_val,
  input  logic [W-1:0] operands_bits_A,
  input  logic [W-1:0] operands_bits_B,
  output logic         operands_rdy,
  output logic         req0_val,
  output logic [W-1:0] req0_bits_A,
  output logic [W-1:0] req0_bits_B,
  input  logic         req0_rdy,
  output logic         req1_val,
  output logic [W-1:0] req1_bits_A,
  output logic [W-1:0] req1_bits_B,
  input  logic         req1_rdy,
  input  logic         resp0_val,
  input  logic [W-1:0] resp0_bits,
  output logic         resp0_rdy,
  input  logic         resp1_val,
  input  logic [W-1:0] resp1_bits,
  output logic         resp1_rdy,
  output logic         result_val,
  output logic [W-1:0] result_bits,
  input  logic         result_rdy
);

  logic rr_q, rr_d;
  logic sel, avail, dispatch, collect;
  logic q_full, q_empty, head;

  assign req0_bits_A = operands_bits_A;
  assign req0_bits_B = operands_bits_B;
  assign req1_bits_A = operands_bits_A;
  assign req1_bits_B = operands_bits_B;

  // operands_rdy depends only on the count, never on result_rdy.
  assign avail        = !q_full && (req0_rdy || req1_rdy);
  assign operands_rdy = avail;
  assign sel          = pick_unit(rr_q, req0_rdy, req1_rdy);
  assign dispatch     = operands_val && avail;
  assign req0_val     = dispatch && (sel == GCD_UNIT0);
  assign req1_val     = dispatch && (sel == GCD_UNIT1);

  assign result_val  = !q_empty && ((head == GCD_UNIT0) ? resp0_val : resp1_val);
  assign result_bits = (head == GCD_UNIT0) ? resp0_bits : resp1_bits;
  assign resp0_rdy   = !q_empty && result_rdy && (head == GCD_UNIT0);
  assign resp1_rdy   = !q_empty && result_rdy && (head == GCD_UNIT1);
  assign collect     = result_val && result_rdy;

  always_comb begin
    rr_d = rr_q;
    if (dispatch) begin
      rr_d = ~sel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q <= GCD_UNIT0;
    end else begin
      rr_q <= rr_d;
    end
  end

  gcd_arb_tagq #(.LOGDEPTH(LOGDEPTH)) u_tagq (
    .clk     (clk),
    .reset   (reset),
    .push    (dispatch),
    .push_id (sel),
    .pop     (collect),
    .head_id (head),
    .full    (q_full),
    .empty   (q_empty)
  );

endmodule

// File: tb/tb_gcd_arbiter.sv
// Bench for gcd_arbiter: reset-time vector table, directed multi-cycle
// sequences, and a randomized run against an order-queue reference model.
module tb_gcd_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         operands_val;
  logic [W-1:0] operands_bits_A, operands_bits_B;
  logic         operands_rdy;
  logic         req0_val, req1_val, req0_rdy, req1_rdy;
  logic [W-1:0] req0_bits_A, req0_bits_B, req1_bits_A, req1_bits_B;
  logic         resp0_val, resp1_val, resp0_rdy, resp1_rdy;
  logic [W-1:0] resp0_bits, resp1_bits;
  logic         result_val, result_rdy;
  logic [W-1:0] result_bits;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gcd_arbiter #(.W(W), .LOGDEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .operands_val(operands_val), .operands_bits_A(operands_bits_A),
    .operands_bits_B(operands_bits_B), .operands_rdy(operands_rdy),
    .req0_val(req0_val), .req0_bits_A(req0_bits_A), .req0_bits_B(req0_bits_B), .req0_rdy(req0_rdy),
    .req1_val(req1_val), .req1_bits_A(req1_bits_A), .req1_bits_B(req1_bits_B), .req1_rdy(req1_rdy),
    .resp0_val(resp0_val), .resp0_bits(resp0_bits), .resp0_rdy(resp0_rdy),
    .resp1_val(resp1_val), .resp1_bits(resp1_bits), .resp1_rdy(resp1_rdy),
    .result_val(result_val), .result_bits(result_bits), .result_rdy(result_rdy)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    operands_val = 0; operands_bits_A = 0; operands_bits_B = 0;
    req0_rdy = 0; req1_rdy = 0;
    resp0_val = 0; resp1_val = 0; resp0_bits = 0; resp1_bits = 0;
    result_rdy = 0;
  endtask

  task automatic apply_reset();
    reset = 1;
    drive_idle();
    tick();
    tick();
    reset = 0;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    operands_val = 1; operands_bits_A = a; operands_bits_B = b;
  endtask

  typedef struct {
    logic op_val, r0, r1, v0, v1, rrdy;
    logic e_ordy, e_q0, e_q1, e_res, e_rs0, e_rs1;
  } vec_t;
  vec_t vecs[8];

  // Unit emulator and reference model state for the random run.
  logic         busy[2];
  logic         done[2];
  int           timer[2];
  logic [W-1:0] res[2];
  int           m_rr;
  int           m_order[$];
  logic [W-1:0] exp_q[$];

  initial begin
    reset = 1;
    drive_idle();

    // Reset-time combinational vectors: queue empty, preferred unit 0.
    vecs[0] = '{1,1,1,0,0,1, 1,1,0,0,0,0};
    vecs[1] = '{1,0,1,0,0,1, 1,0,1,0,0,0};
    vecs[2] = '{1,1,0,0,0,0, 1,1,0,0,0,0};
    vecs[3] = '{1,0,0,0,0,1, 0,0,0,0,0,0};
    vecs[4] = '{0,1,1,0,0,0, 1,0,0,0,0,0};
    vecs[5] = '{1,1,1,1,1,1, 1,1,0,0,0,0};
    vecs[6] = '{0,0,1,1,0,1, 1,0,0,0,0,0};
    vecs[7] = '{0,0,0,0,1,1, 0,0,0,0,0,0};
    tick();
    for (int i = 0; i < 8; i++) begin
      operands_val = vecs[i].op_val; req0_rdy = vecs[i].r0; req1_rdy = vecs[i].r1;
      resp0_val = vecs[i].v0; resp1_val = vecs[i].v1; result_rdy = vecs[i].rrdy;
      resp0_bits = 11; resp1_bits = 22;
      #1;
      chk($sformatf("vec%0d_ordy", i), operands_rdy, vecs[i].e_ordy);
      chk($sformatf("vec%0d_req0_val", i), req0_val, vecs[i].e_q0);
      chk($sformatf("vec%0d_req1_val", i), req1_val, vecs[i].e_q1);
      chk($sformatf("vec%0d_result_val", i), result_val, vecs[i].e_res);
      chk($sformatf("vec%0d_resp0_rdy", i), resp0_rdy, vecs[i].e_rs0);
      chk($sformatf("vec%0d_resp1_rdy", i), resp1_rdy, vecs[i].e_rs1);
    end

    // Single request through unit 0.
    apply_reset();
    req0_rdy = 1; req1_rdy = 1; send(48, 18);
    #1;
    chk("t1_req0_val", req0_val, 1);
    chk("t1_req1_val", req1_val, 0);
    chk("t1_req0_A", req0_bits_A, 48);
    chk("t1_req0_B", req0_bits_B, 18);
    tick();
    chk("t1_rr", dut.rr_q, 1);
    operands_val = 0; req0_rdy = 0;
    resp0_val = 1; resp0_bits = 6; result_rdy = 1;
    #1;
    chk("t1_result_val", result_val, 1);
    chk("t1_result_bits", result_bits, 6);
    chk("t1_resp0_rdy", resp0_rdy, 1);
    tick();
    resp0_val = 0;
    #1;
    chk("t1_empty_after", result_val, 0);

    // Out-of-order completion is returned in request order.
    apply_reset();
    req0_rdy = 1; req1_rdy = 1; send(27, 9);
    #1;
    chk("t2_first_u0", req0_val, 1);
    tick();
    send(35, 14);
    #1;
    chk("t2_second_u1", req1_val, 1);
    tick();
    drive_idle();
    resp1_val = 1; resp1_bits = 7; result_rdy = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_stall_val", result_val, 0);
      chk("t2_stall_resp1_rdy", resp1_rdy, 0);
      tick();
    end
    resp0_val = 1; resp0_bits = 9;
    #1;
    chk("t2_first_bits", result_bits, 9);
    chk("t2_first_resp1_rdy", resp1_rdy, 0);
    chk("t2_first_resp0_rdy", resp0_rdy, 1);
    tick();
    resp0_val = 0;
    #1;
    chk("t2_second_val", result_val, 1);
    chk("t2_second_bits", result_bits, 7);
    chk("t2_second_resp1_rdy", resp1_rdy, 1);
    tick();
    resp1_val = 0;
    #1;
    chk("t2_drained", result_val, 0);

    // Preferred unit busy: fall back to unit 1, preference returns to 0.
    apply_reset();
    req0_rdy = 0; req1_rdy = 1; send(10, 4);
    #1;
    chk("t3_ordy", operands_rdy, 1);
    chk("t3_req0_val", req0_val, 0);
    chk("t3_req1_val", req1_val, 1);
    tick();
    chk("t3_rr", dut.rr_q, 0);
    req0_rdy = 1; send(3, 3);
    #1;
    chk("t3_next_u0", req0_val, 1);

    // Fill the order queue, check no full bypass, drain in order.
    apply_reset();
    req0_rdy = 1; req1_rdy = 1;
    send(12, 8);  #1; chk("t4_ordy0", operands_rdy, 1); tick();
    send(21, 14); #1; chk("t4_ordy1", operands_rdy, 1); tick();
    send(30, 12); #1; chk("t4_ordy2", operands_rdy, 1); tick();
    send(100, 75); #1; chk("t4_ordy3", operands_rdy, 1); tick();
    send(5, 5);
    #1;
    chk("t4_full_ordy", operands_rdy, 0);
    resp0_val = 1; resp0_bits = 4; resp1_val = 1; resp1_bits = 7; result_rdy = 1;
    #1;
    chk("t4_pop_bits0", result_bits, 4);
    chk("t4_no_bypass", operands_rdy, 0);
    tick();
    operands_val = 0; resp0_bits = 6;
    #1;
    chk("t4_ordy_after_pop", operands_rdy, 1);
    chk("t4_pop_bits1", result_bits, 7);
    tick();
    resp1_bits = 25;
    #1;
    chk("t4_pop_bits2", result_bits, 6);
    tick();
    #1;
    chk("t4_pop_bits3", result_bits, 25);
    tick();
    #1;
    chk("t4_drained", result_val, 0);

    // Simultaneous push and pop at count 2.
    apply_reset();
    req0_rdy = 1; req1_rdy = 1;
    send(8, 12); tick();
    send(9, 6);  tick();
    send(5, 10); resp0_val = 1; resp0_bits = 4; result_rdy = 1;
    #1;
    chk("t5_result_val", result_val, 1);
    chk("t5_push_val", req0_val, 1);
    tick();
    drive_idle();
    #1;
    chk("t5_count", dut.u_tagq.count_q, 2);
    chk("t5_head", dut.u_tagq.head_q, 1);
    chk("t5_tail", dut.u_tagq.tail_q, 3);

    // Async reset with two requests in flight.
    apply_reset();
    req0_rdy = 1; req1_rdy = 1;
    send(8, 12); tick();
    send(9, 6);  tick();
    drive_idle();
    resp0_val = 1; resp0_bits = 3; result_rdy = 1;
    #1;
    chk("t6_pre_val", result_val, 1);
    reset = 1;
    #1;
    chk("t6_async_val", result_val, 0);
    chk("t6_async_resp0_rdy", resp0_rdy, 0);
    chk("t6_rr", dut.rr_q, 0);
    tick();
    reset = 0; resp0_val = 0;
    #1;
    chk("t6_count", dut.u_tagq.count_q, 0);
    req0_rdy = 1; req1_rdy = 1; send(7, 21);
    #1;
    chk("t6_next_u0", req0_val, 1);
    chk("t6_next_not_u1", req1_val, 0);

    // Randomized run against the reference model.
    apply_reset();
    for (int u = 0; u < 2; u++) begin
      busy[u] = 0; done[u] = 0; timer[u] = 0; res[u] = 0;
    end
    m_rr = 0;
    m_order.delete();
    exp_q.delete();
    begin
      int ndisp, e_sel, h;
      logic e_avail, e_disp, e_rval, e_coll;
      logic [W-1:0] a, b, da, db;
      ndisp = 0;
      for (int cyc = 0; cyc < 700; cyc++) begin
        operands_val    = (cyc < 550) && ($urandom_range(0, 2) != 0);
        operands_bits_A = $urandom_range(1, 255);
        operands_bits_B = $urandom_range(1, 255);
        result_rdy      = ($urandom_range(0, 3) != 0);
        req0_rdy = !busy[0]; req1_rdy = !busy[1];
        resp0_val = done[0]; resp1_val = done[1];
        resp0_bits = res[0]; resp1_bits = res[1];
        #1;
        e_avail = (m_order.size() < 4) && (req0_rdy || req1_rdy);
        e_sel   = ((m_rr == 0) ? req0_rdy : req1_rdy) ? m_rr : 1 - m_rr;
        e_disp  = operands_val && e_avail;
        h       = (m_order.size() > 0) ? m_order[0] : 0;
        e_rval  = (m_order.size() > 0) && done[h];
        e_coll  = e_rval && result_rdy;
        chk("rnd_ordy", operands_rdy, e_avail);
        chk("rnd_req0_val", req0_val, e_disp && (e_sel == 0));
        chk("rnd_req1_val", req1_val, e_disp && (e_sel == 1));
        chk("rnd_result_val", result_val, e_rval);
        if (e_rval) chk("rnd_result_bits", result_bits, exp_q[0]);
        chk("rnd_resp0_rdy", resp0_rdy, (m_order.size() > 0) && result_rdy && (h == 0));
        chk("rnd_resp1_rdy", resp1_rdy, (m_order.size() > 0) && result_rdy && (h == 1));
        a  = operands_bits_A; b = operands_bits_B;
        da = (e_sel == 1) ? req1_bits_A : req0_bits_A;
        db = (e_sel == 1) ? req1_bits_B : req0_bits_B;
        @(posedge clk);
        for (int u = 0; u < 2; u++) begin
          if (busy[u] && !done[u]) begin
            if (timer[u] == 0) done[u] = 1;
            else timer[u]--;
          end
        end
        if (e_coll) begin
          h = m_order.pop_front();
          void'(exp_q.pop_front());
          busy[h] = 0; done[h] = 0;
        end
        if (e_disp) begin
          m_order.push_back(e_sel);
          exp_q.push_back(gcd_ref(a, b));
          busy[e_sel] = 1; done[e_sel] = 0;
          timer[e_sel] = $urandom_range(0, 4);
          res[e_sel] = gcd_ref(da, db);
          m_rr = 1 - e_sel;
          ndisp++;
        end
        #1;
      end
      chk("rnd_drained", exp_q.size(), 0);
      chk("rnd_wrap_cover", (ndisp >= 9), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
